// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encodings and control-strobe bundle for the RISC CPU
package cpu_pkg;

  localparam int STATE_W = 4;

  localparam logic [2:0] HLT  = 3'b000;
  localparam logic [2:0] SKZ  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100;
  localparam logic [2:0] LDA  = 3'b101;
  localparam logic [2:0] STO  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  localparam logic [STATE_W-1:0] S0     = 4'd0;
  localparam logic [STATE_W-1:0] S1     = 4'd1;
  localparam logic [STATE_W-1:0] S2     = 4'd2;
  localparam logic [STATE_W-1:0] S3     = 4'd3;
  localparam logic [STATE_W-1:0] S4     = 4'd4;
  localparam logic [STATE_W-1:0] S5     = 4'd5;
  localparam logic [STATE_W-1:0] S6     = 4'd6;
  localparam logic [STATE_W-1:0] S7     = 4'd7;
  localparam logic [STATE_W-1:0] HALTED = 4'd8;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/machine_fsm_decode.sv
// rtl/machine_fsm_decode.sv - combinational next-state and next-strobe decode of the instruction cycle
module machine_fsm_decode
  import cpu_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic [STATE_W-1:0] next_state,
  output ctl_t               next_ctl
);

  always_comb begin
    next_state = S0;
    case (state)
      S0, S1, S2, S4, S5, S6: next_state = state + 4'd1;
      S3:     next_state = (opcode == HLT && HALT_STICKY) ? HALTED : S4;
      S7:     next_state = S0;
      HALTED: next_state = HALTED;
      default: next_state = S0;
    endcase
  end

  always_comb begin
    next_ctl = '0;
    case (state)
      S0: begin
        next_ctl.rd      = 1'b1;
        next_ctl.load_ir = 1'b1;
      end
      S1: begin
        next_ctl.rd      = 1'b1;
        next_ctl.load_ir = 1'b1;
        next_ctl.inc_pc  = 1'b1;
      end
      S3: begin
        next_ctl.inc_pc = 1'b1;
        next_ctl.halt   = (opcode == HLT);
      end
      S4: begin
        next_ctl.load_pc     = (opcode == JMP);
        next_ctl.rd          = is_aluop(opcode);
        next_ctl.datactl_ena = (opcode == STO);
      end
      S5: begin
        next_ctl.rd          = is_aluop(opcode);
        next_ctl.load_acc    = is_aluop(opcode);
        next_ctl.inc_pc      = (opcode == SKZ && zero) || (opcode == JMP);
        next_ctl.load_pc     = (opcode == JMP);
        next_ctl.wr          = (opcode == STO);
        next_ctl.datactl_ena = (opcode == STO);
      end
      S6: begin
        next_ctl.halt        = (opcode == HLT);
        next_ctl.rd          = is_aluop(opcode);
        next_ctl.datactl_ena = (opcode == STO);
      end
      S7: next_ctl.inc_pc = (opcode == SKZ && zero);
      HALTED: next_ctl.halt = 1'b1;
      default: next_ctl = '0;
    endcase
  end

endmodule

// File: rtl/machine_fsm.sv
// rtl/machine_fsm.sv - instruction-cycle control FSM: state and registered control strobes
module machine_fsm
  import cpu_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  ctl_t               ctl;
  ctl_t               next_ctl;

  machine_fsm_decode #(
    .HALT_STICKY(HALT_STICKY)
  ) u_decode (
    .state      (state),
    .opcode     (opcode),
    .zero       (zero),
    .next_state (next_state),
    .next_ctl   (next_ctl)
  );

  // Strobes are registered alongside the state, so they lag it by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S0;
      ctl   <= '0;
    end else if (!ena) begin
      state <= S0;
      ctl   <= '0;
    end else begin
      state <= next_state;
      ctl   <= next_ctl;
    end
  end

  assign inc_pc      = ctl.inc_pc;
  assign load_acc    = ctl.load_acc;
  assign load_pc     = ctl.load_pc;
  assign rd          = ctl.rd;
  assign wr          = ctl.wr;
  assign load_ir     = ctl.load_ir;
  assign datactl_ena = ctl.datactl_ena;
  assign halt        = ctl.halt;

endmodule
